// File: rtl/regfile_pkg.sv
// Shared constants and the address-width helper for the register file and its read muxes.
package regfile_pkg;

  localparam int DEFAULT_WORD_LENGTH = 32;
  localparam int DEFAULT_NUM_REGS    = 32;

  // Smallest n with 2**n >= value; used at elaboration time only.
  function automatic int CeilLog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_n_to_1.sv
// Parameterised N-to-1 word multiplexer; a select beyond NUM_INPUTS-1 yields zero.
module mux_n_to_1
  import regfile_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
  parameter int NUM_INPUTS  = DEFAULT_NUM_REGS,
  parameter int SEL_BITS    = CeilLog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0][WORD_LENGTH-1:0] data_in,
  input  logic [SEL_BITS-1:0]                    sel,
  output logic [WORD_LENGTH-1:0]                 data_out
);

  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (sel == SEL_BITS'(i)) data_out = data_in[i];
    end
  end

endmodule

// File: rtl/multiport_register_file.sv
// One-write, two-read register file with optional hardwired zero register and
// optional registered read ports that bypass a same-cycle write (write-first).
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int WORD_LENGTH     = DEFAULT_WORD_LENGTH,
  parameter int NUM_REGS        = DEFAULT_NUM_REGS,
  parameter int NBITS           = CeilLog2(NUM_REGS),
  parameter bit ZERO_REG        = 1'b1,
  parameter bit READ_REGISTERED = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Write_Enable,
  input  logic [NBITS-1:0]       Write_Register,
  input  logic [WORD_LENGTH-1:0] Write_Data,
  input  logic [NBITS-1:0]       Read_Register_1,
  input  logic [NBITS-1:0]       Read_Register_2,
  output logic [WORD_LENGTH-1:0] Read_Data_1,
  output logic [WORD_LENGTH-1:0] Read_Data_2
);

  // One extra bit so NUM_REGS == 2**NBITS is representable in the range check.
  localparam logic [NBITS:0] NUM_REGS_W = (NBITS + 1)'(NUM_REGS);

  logic [NUM_REGS-1:0][WORD_LENGTH-1:0] regs_d, regs_q;
  logic [NUM_REGS-1:0][WORD_LENGTH-1:0] read_src;
  logic [WORD_LENGTH-1:0]               mux_data_1, mux_data_2;
  logic                                 write_ok;

  always_comb begin
    write_ok = Write_Enable
            && ({1'b0, Write_Register} < NUM_REGS_W)
            && !(ZERO_REG && (Write_Register == '0));
  end

  always_comb begin
    regs_d = regs_q;
    if (write_ok) regs_d[Write_Register] = Write_Data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  // Register 0 is never written when hardwired, but force it anyway so the read path never depends on that.
  always_comb begin
    read_src = regs_q;
    if (ZERO_REG) read_src[0] = '0;
  end

  mux_n_to_1 #(
    .WORD_LENGTH(WORD_LENGTH),
    .NUM_INPUTS (NUM_REGS),
    .SEL_BITS   (NBITS)
  ) u_rd1_mux (
    .data_in (read_src),
    .sel     (Read_Register_1),
    .data_out(mux_data_1)
  );

  mux_n_to_1 #(
    .WORD_LENGTH(WORD_LENGTH),
    .NUM_INPUTS (NUM_REGS),
    .SEL_BITS   (NBITS)
  ) u_rd2_mux (
    .data_in (read_src),
    .sel     (Read_Register_2),
    .data_out(mux_data_2)
  );

  generate
    if (READ_REGISTERED) begin : g_read_reg
      logic [WORD_LENGTH-1:0] rd1_d, rd1_q, rd2_d, rd2_q;

      // write_ok already excludes out-of-range and hardwired-zero targets, so bypass needs no extra guard.
      always_comb begin
        rd1_d = mux_data_1;
        rd2_d = mux_data_2;
        if (write_ok && (Read_Register_1 == Write_Register)) rd1_d = Write_Data;
        if (write_ok && (Read_Register_2 == Write_Register)) rd2_d = Write_Data;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd1_q <= '0;
          rd2_q <= '0;
        end else begin
          rd1_q <= rd1_d;
          rd2_q <= rd2_d;
        end
      end

      assign Read_Data_1 = rd1_q;
      assign Read_Data_2 = rd2_q;
    end else begin : g_read_comb
      assign Read_Data_1 = mux_data_1;
      assign Read_Data_2 = mux_data_2;
    end
  endgenerate

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file across five parameterisations sharing one stimulus bus.
module tb_multiport_register_file;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic [4:0]  ra1, ra2;

  logic [31:0] rd1_c, rd2_c;   // defaults: combinational read, zero reg
  logic [31:0] rd1_r, rd2_r;   // registered read
  logic [31:0] rd1_n, rd2_n;   // no zero register
  logic [31:0] rd1_o, rd2_o;   // 20 registers
  logic [7:0]  rd1_s, rd2_s;   // 8-bit, 4 registers

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  multiport_register_file u_c (
    .clk(clk), .reset(reset), .Write_Enable(we), .Write_Register(wreg), .Write_Data(wdata),
    .Read_Register_1(ra1), .Read_Register_2(ra2), .Read_Data_1(rd1_c), .Read_Data_2(rd2_c));

  multiport_register_file #(.READ_REGISTERED(1'b1)) u_r (
    .clk(clk), .reset(reset), .Write_Enable(we), .Write_Register(wreg), .Write_Data(wdata),
    .Read_Register_1(ra1), .Read_Register_2(ra2), .Read_Data_1(rd1_r), .Read_Data_2(rd2_r));

  multiport_register_file #(.ZERO_REG(1'b0)) u_n (
    .clk(clk), .reset(reset), .Write_Enable(we), .Write_Register(wreg), .Write_Data(wdata),
    .Read_Register_1(ra1), .Read_Register_2(ra2), .Read_Data_1(rd1_n), .Read_Data_2(rd2_n));

  multiport_register_file #(.NUM_REGS(20)) u_o (
    .clk(clk), .reset(reset), .Write_Enable(we), .Write_Register(wreg), .Write_Data(wdata),
    .Read_Register_1(ra1), .Read_Register_2(ra2), .Read_Data_1(rd1_o), .Read_Data_2(rd2_o));

  multiport_register_file #(.WORD_LENGTH(8), .NUM_REGS(4)) u_s (
    .clk(clk), .reset(reset), .Write_Enable(we), .Write_Register(wreg[1:0]), .Write_Data(wdata[7:0]),
    .Read_Register_1(ra1[1:0]), .Read_Register_2(ra2[1:0]), .Read_Data_1(rd1_s), .Read_Data_2(rd2_s));

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the edge that performed the write.
  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wreg = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic set_read(input logic [4:0] a1, input logic [4:0] a2);
    ra1 = a1; ra2 = a2;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; we = 1'b0; wreg = '0; wdata = '0; ra1 = 5'd7; ra2 = 5'd7;
    repeat (2) @(posedge clk);
    #1;
    check("reset_comb_rd1", rd1_c, 32'h0);
    check("reset_regd_rd1", rd1_r, 32'h0);

    // Write attempted while held in reset must be dropped.
    we = 1'b1; wreg = 5'd3; wdata = 32'h55;
    @(posedge clk); #1;
    we = 1'b0; reset = 1'b1;
    set_read(5'd3, 5'd3);
    check("write_during_reset", rd1_c, 32'h0);

    // Reset mid-cycle clears immediately.
    write_reg(5'd7, 32'hA5A5_A5A5);
    set_read(5'd7, 5'd7);
    check("pre_reset_comb", rd1_c, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    check("pre_reset_regd", rd1_r, 32'hA5A5_A5A5);
    #1 reset = 1'b0;
    #1;
    check("async_reset_comb", rd1_c, 32'h0);
    check("async_reset_regd", rd1_r, 32'h0);
    we = 1'b1; wreg = 5'd9; wdata = 32'h99;
    @(posedge clk); #1;
    reset = 1'b1; we = 1'b0;
    set_read(5'd9, 5'd7);
    check("write_at_reset_dropped", rd1_c, 32'h0);
    check("reg7_after_reset", rd2_c, 32'h0);

    // Write_Enable low is a no-op.
    wreg = 5'd6; wdata = 32'hBEEF;
    @(posedge clk); #1;
    set_read(5'd6, 5'd6);
    check("we_low_noop", rd1_c, 32'h0);

    // Same-cycle write/read: combinational sees old value, registered bypasses.
    set_read(5'd5, 5'd5);
    we = 1'b1; wreg = 5'd5; wdata = 32'h1234;
    #1;
    check("bypass_comb_old_rd1", rd1_c, 32'h0);
    check("bypass_comb_old_rd2", rd2_c, 32'h0);
    @(posedge clk); #1;
    we = 1'b0;
    check("bypass_regd_rd1", rd1_r, 32'h1234);
    check("bypass_regd_rd2", rd2_r, 32'h1234);
    check("bypass_comb_new_rd1", rd1_c, 32'h1234);
    check("bypass_comb_new_rd2", rd2_c, 32'h1234);

    // Fill reg i = i*3 and read back forward on port 1, reversed on port 2.
    exp_q.push_back(32'h0);
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'(i * 3));
      exp_q.push_back(32'(i * 3));
    end
    for (int i = 1; i < 32; i++) begin
      set_read(5'(i), 5'(32 - i));
      @(posedge clk); #1;
      check($sformatf("fill_comb_rd1[%0d]", i), rd1_c, exp_q[i]);
      check($sformatf("fill_comb_rd2[%0d]", 32 - i), rd2_c, exp_q[32 - i]);
      check($sformatf("fill_regd_rd1[%0d]", i), rd1_r, exp_q[i]);
      check($sformatf("fill_regd_rd2[%0d]", 32 - i), rd2_r, exp_q[32 - i]);
      check($sformatf("fill_nz_rd1[%0d]", i), rd1_n, exp_q[i]);
      check($sformatf("fill_oor_rd1[%0d]", i), rd1_o, (i < 20) ? exp_q[i] : 32'h0);
    end

    // Register 0 behaviour with and without the hardwired zero.
    write_reg(5'd0, 32'hFFFF_FFFF);
    set_read(5'd0, 5'd0);
    check("zero_reg_comb", rd1_c, 32'h0);
    check("zero_reg_off", rd1_n, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("zero_reg_regd", rd2_r, 32'h0);

    // Out-of-range write on the 20-entry file.
    write_reg(5'd25, 32'hDEAD);
    set_read(5'd25, 5'd25);
    check("oor_read_rd1", rd1_o, 32'h0);
    check("oor_read_rd2", rd2_o, 32'h0);
    check("in_range_32_reg25", rd1_c, 32'hDEAD);
    for (int i = 0; i < 20; i++) begin
      set_read(5'(i), 5'(19 - i));
      check($sformatf("oor_unchanged[%0d]", i), rd1_o, exp_q[i]);
    end

    // Narrow 4 x 8-bit file, starting from a clean reset.
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    write_reg(5'd3, 32'hFF);
    set_read(5'd0, 5'd3);
    check("small_rd2_reg3", {24'h0, rd2_s}, 32'hFF);
    check("small_rd1_reg0", {24'h0, rd1_s}, 32'h0);
    set_read(5'd2, 5'd2);
    check("small_rd2_reg2", {24'h0, rd2_s}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
